// File: rtl/sprite_renderer.sv
// Sprite renderer: one animated, scalable, flippable sprite over the VGA raster.
// Position/flip are double-buffered and latched at the frame boundary.
module sprite_renderer #(
  parameter int SPR_W           = 20,
  parameter int SPR_H           = 20,
  parameter int SCALE_LOG2      = 0,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_PERIOD    = 8,
  parameter int IDX_W           = 5,
  parameter int TRANSPARENT_IDX = 0,
  parameter int V_ACTIVE        = 480,
  parameter int ADDR_W          = $clog2(NUM_FRAMES*SPR_W*SPR_H),
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              pos_valid,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit,
  output logic [FW-1:0]     anim_frame
);

  localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);

  logic [9:0]        req_x_q, req_x_d, req_y_q, req_y_d;
  logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
  logic              req_flip_q, req_flip_d, act_flip_q, act_flip_d;
  logic              pending_q, pending_d;
  logic [PW-1:0]     period_q, period_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              in_box1_q, in_box1_d, blank1_q, blank1_d;
  logic              in_box2_q, in_box2_d, blank2_q, blank2_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              hit_q, hit_d;

  logic              boundary;
  logic [10:0]       dx, dy, lx, ly;
  logic              in_box;
  logic [ADDR_W-1:0] addr;
  logic              opaque;

  assign boundary = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

  always_comb begin
    req_x_d    = req_x_q;
    req_y_d    = req_y_q;
    req_flip_d = req_flip_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    act_flip_d = act_flip_q;
    pending_d  = pending_q;
    period_d   = period_q;
    frame_d    = frame_q;
    if (boundary) begin
      if (pending_q) begin
        act_x_d    = req_x_q;
        act_y_d    = req_y_q;
        act_flip_d = req_flip_q;
        pending_d  = 1'b0;
      end
      if (anim_en) begin
        if (period_q == PW'(FRAME_PERIOD - 1)) begin
          period_d = '0;
          frame_d  = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          period_d = period_q + 1'b1;
        end
      end
    end
    // A strobe in the boundary cycle itself waits for the next boundary
    if (pos_valid) begin
      req_x_d    = pos_x;
      req_y_d    = pos_y;
      req_flip_d = flip_h;
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, act_x_q};
    dy     = {1'b0, DrawY} - {1'b0, act_y_q};
    in_box = !dx[10] && !dy[10] && (dx < BOX_W) && (dy < BOX_H);
    lx     = dx >> SCALE_LOG2;
    ly     = dy >> SCALE_LOG2;
    if (act_flip_q) begin
      lx = 11'(SPR_W - 1) - lx;
    end
    addr = ADDR_W'(frame_q) * FRAME_SZ
         + ADDR_W'(ly) * ADDR_W'(SPR_W)
         + ADDR_W'(lx);
    rom_address_d = in_box ? addr : '0;
    in_box1_d     = in_box;
    blank1_d      = blank;
    in_box2_d     = in_box1_q;
    blank2_d      = blank1_q;
  end

  always_comb begin
    opaque  = blank2_q && in_box2_q
            && (rom_q != IDX_W'(TRANSPARENT_IDX));
    red_d   = opaque ? pal_red   : 4'd0;
    green_d = opaque ? pal_green : 4'd0;
    blue_d  = opaque ? pal_blue  : 4'd0;
    hit_d   = opaque;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      req_x_q       <= '0;
      req_y_q       <= '0;
      req_flip_q    <= 1'b0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      act_flip_q    <= 1'b0;
      pending_q     <= 1'b0;
      period_q      <= '0;
      frame_q       <= '0;
      rom_address_q <= '0;
      in_box1_q     <= 1'b0;
      blank1_q      <= 1'b0;
      in_box2_q     <= 1'b0;
      blank2_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hit_q         <= 1'b0;
    end else begin
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      req_flip_q    <= req_flip_d;
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      act_flip_q    <= act_flip_d;
      pending_q     <= pending_d;
      period_q      <= period_d;
      frame_q       <= frame_d;
      rom_address_q <= rom_address_d;
      in_box1_q     <= in_box1_d;
      blank1_q      <= blank1_d;
      in_box2_q     <= in_box2_d;
      blank2_q      <= blank2_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hit_q         <= hit_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign sprite_hit  = hit_q;
  assign anim_frame  = frame_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: scoreboard of expected ROM addresses and pixels,
// two instances (unscaled with FRAME_PERIOD=2, and 2x scaled).
module tb_sprite_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [9:0] draw_x, draw_y, pos_x, pos_y;
  logic       blank, flip_h, pos_valid, anim_en;

  logic [10:0] ra0, ra1;
  logic [4:0]  rq0, rq1, pi0, pi1;
  logic [3:0]  pr0, pg0, pb0, pr1, pg1, pb1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hit0, hit1;
  logic [1:0]  af0, af1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    int          dut;
    logic [15:0] val;
    string       tag;
  } exp_t;
  exp_t aq[$];
  exp_t oq[$];

  function automatic logic [4:0] rom_f(input logic [10:0] a);
    logic [10:0] t;
    t = a * 11'd3 + 11'd7;
    return t[4:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rq0 <= rom_f(ra0);
  always @(posedge clk) rq1 <= rom_f(ra1);
  assign pr0 = pi0[3:0];
  assign pg0 = pi0[4:1];
  assign pb0 = ~pi0[3:0];
  assign pr1 = pi1[3:0];
  assign pg1 = pi1[4:1];
  assign pb1 = ~pi1[3:0];

  sprite_renderer #(.FRAME_PERIOD(2)) dut0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .pos_valid(pos_valid), .anim_en(anim_en), .rom_address(ra0),
    .rom_q(rq0), .pal_index(pi0), .pal_red(pr0), .pal_green(pg0),
    .pal_blue(pb0), .red(r0), .green(g0), .blue(b0),
    .sprite_hit(hit0), .anim_frame(af0)
  );

  sprite_renderer #(.SCALE_LOG2(1)) dut1 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
    .pos_valid(pos_valid), .anim_en(anim_en), .rom_address(ra1),
    .rom_q(rq1), .pal_index(pi1), .pal_red(pr1), .pal_green(pg1),
    .pal_blue(pb1), .red(r1), .green(g1), .blue(b1),
    .sprite_hit(hit1), .anim_frame(af1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      e = aq.pop_front();
      check_eq({e.tag, "_addr"}, {21'd0, (e.dut != 0) ? ra1 : ra0}, {16'd0, e.val});
    end
    while (oq.size() > 0 && oq[0].due <= cyc) begin
      e = oq.pop_front();
      if (e.dut != 0)
        check_eq({e.tag, "_pix"}, {19'd0, hit1, r1, g1, b1}, {16'd0, e.val});
      else
        check_eq({e.tag, "_pix"}, {19'd0, hit0, r0, g0, b0}, {16'd0, e.val});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    draw_x    = 10'd700;
    draw_y    = 10'd600;
    blank     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input int x, input int y, input logic f);
    pos_x     = 10'(x);
    pos_y     = 10'(y);
    flip_h    = f;
    pos_valid = 1'b1;
    step();
  endtask

  task automatic boundary();
    draw_x = 10'd0;
    draw_y = 10'd480;
    blank  = 1'b0;
    step();
  endtask

  // ea < 0 means the pixel lies outside the sprite box
  task automatic pix(input int x, input int y, input logic bl,
                     input int dut, input int ea, input string tag);
    exp_t e;
    logic [10:0] a;
    logic [4:0]  idx;
    logic        hit;
    a      = (ea < 0) ? 11'd0 : 11'(ea);
    idx    = rom_f(a);
    hit    = (ea >= 0) && bl && (idx != 5'd0);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = bl;
    e.dut  = dut;
    e.tag  = tag;
    e.due  = cyc + 1;
    e.val  = {5'd0, a};
    aq.push_back(e);
    e.due  = cyc + 3;
    e.val  = hit ? {3'd0, 1'b1, idx[3:0], idx[4:1], ~idx[3:0]} : 16'd0;
    oq.push_back(e);
    step();
  endtask

  initial begin
    int ef;
    reset_n   = 1'b0;
    pos_x     = '0;
    pos_y     = '0;
    flip_h    = 1'b0;
    pos_valid = 1'b0;
    anim_en   = 1'b0;
    draw_x    = 10'd700;
    draw_y    = 10'd600;
    blank     = 1'b0;
    idle(3);
    check_eq("rst_out0", {19'd0, hit0, r0, g0, b0}, 32'd0);
    check_eq("rst_out1", {19'd0, hit1, r1, g1, b1}, 32'd0);
    check_eq("rst_addr", {10'd0, ra0, ra1}, 32'd0);
    check_eq("rst_anim", {28'd0, af0, af1}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    strobe(100, 50, 1'b0);
    boundary();
    pix(100, 50, 1'b1, 0, 0, "tl");
    pix(119, 69, 1'b1, 0, 399, "br");
    pix(120, 50, 1'b1, 0, -1, "right_out");
    pix(99, 50, 1'b1, 0, -1, "left_out");
    pix(100, 70, 1'b1, 0, -1, "below_out");
    pix(119, 50, 1'b1, 0, 19, "transp");
    pix(105, 55, 1'b0, 0, 105, "blanked");
    pix(110, 52, 1'b1, 0, 50, "mid");

    strobe(1, 1, 1'b0);
    strobe(300, 200, 1'b0);
    pix(100, 50, 1'b1, 0, 0, "old_pos");
    pix(300, 200, 1'b1, 0, -1, "new_not_yet");
    pos_x = 10'd630;
    pos_y = 10'd0;
    flip_h = 1'b0;
    pos_valid = 1'b1;
    boundary();
    pix(300, 200, 1'b1, 0, 0, "new_pos");
    pix(301, 201, 1'b1, 0, 21, "new_pos2");
    pix(100, 50, 1'b1, 0, -1, "old_gone");
    pix(1, 1, 1'b1, 0, -1, "lastwins");
    boundary();
    pix(630, 0, 1'b1, 0, 0, "edge_tl");
    pix(639, 0, 1'b1, 0, 9, "edge_r");
    pix(639, 19, 1'b1, 0, 389, "edge_br");
    pix(0, 0, 1'b1, 0, -1, "nowrap0");
    pix(5, 0, 1'b1, 0, -1, "nowrap5");

    strobe(0, 0, 1'b1);
    boundary();
    pix(0, 0, 1'b1, 0, 19, "flip0");
    pix(19, 0, 1'b1, 0, 0, "flip19");
    pix(5, 2, 1'b1, 0, 54, "flip_mid");
    pix(20, 0, 1'b1, 0, -1, "flip_out");

    strobe(0, 0, 1'b0);
    boundary();
    pix(0, 0, 1'b1, 1, 0, "sc00");
    pix(1, 0, 1'b1, 1, 0, "sc10");
    pix(0, 1, 1'b1, 1, 0, "sc01");
    pix(1, 1, 1'b1, 1, 0, "sc11");
    pix(2, 0, 1'b1, 1, 1, "sc20");
    pix(0, 2, 1'b1, 1, 20, "sc02");
    pix(39, 39, 1'b1, 1, 399, "sc_br");
    pix(40, 0, 1'b1, 1, -1, "sc_out");

    anim_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      boundary();
      ef = (k / 2) % 4;
      check_eq($sformatf("anim_b%0d", k), {30'd0, af0}, ef);
      pix(0, 0, 1'b1, 0, 400 * ef, $sformatf("anim_px%0d", k));
    end
    anim_en = 1'b0;
    boundary();
    boundary();
    check_eq("anim_frozen", {30'd0, af0}, 32'd1);
    pix(0, 0, 1'b1, 0, 400, "frozen_px");
    idle(4);

    strobe(200, 100, 1'b0);
    draw_x = 10'd3;
    draw_y = 10'd3;
    blank  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_out", {19'd0, hit0, r0, g0, b0}, 32'd0);
    check_eq("midrst_addr", {21'd0, ra0}, 32'd0);
    check_eq("midrst_anim", {30'd0, af0}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    boundary();
    pix(200, 100, 1'b1, 0, -1, "pend_cleared");
    pix(0, 0, 1'b1, 0, 0, "after_rst");
    pix(19, 19, 1'b1, 0, 399, "after_rst_br");

    for (int i = 0; i < 10 && (aq.size() > 0 || oq.size() > 0); i++) idle(1);
    check_eq("drain", aq.size() + oq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
